// File: rtl/muldiv_unit_pkg.sv
// Shared types for the iterative multiply/divide unit: operand word, op select and FSM states.
package muldiv_unit_pkg;
  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [2:0] {
    MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE, CALC, FIX, DONE
  } muldiv_state_t;
endpackage

// File: rtl/muldiv_if.sv
// Bundle of the multiply/divide unit signals; md faces the unit, tb faces the driver.
interface muldiv_if;
  import muldiv_unit_pkg::*;
  logic       start, flush, busy, done;
  muldiv_op_t op;
  word_t      port_a, port_b, hi, lo;

  modport md (input start, op, port_a, port_b, flush, output busy, done, hi, lo);
  modport tb (output start, op, port_a, port_b, flush, input busy, done, hi, lo);
endinterface

// File: rtl/muldiv_unit.sv
// MIPS MULT/MULTU/DIV/DIVU over 32 radix-2 steps plus a sign-fix cycle; owns HI/LO.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             start,
  input  muldiv_op_t       op,
  input  logic [WIDTH-1:0] port_a,
  input  logic [WIDTH-1:0] port_b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  muldiv_state_t state_q, state_d;

  logic [4:0]         cnt_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   b_q, a_raw_q, hi_q, lo_q;
  logic               is_div_q, neg_q, rem_neg_q, divz_q;

  logic             accept, accept_md, accept_mt, op_signed, op_div;
  logic [WIDTH-1:0] a_mag, b_mag;

  // DONE accepts like IDLE so back-to-back ops lose no cycle.
  assign accept    = (state_q == IDLE || state_q == DONE) && start && !flush;
  assign accept_mt = accept && (op == MD_MTHI || op == MD_MTLO);
  assign accept_md = accept && !accept_mt;
  assign op_signed = (op == MD_MULT) || (op == MD_DIV);
  assign op_div    = (op == MD_DIV) || (op == MD_DIVU);
  assign a_mag     = (op_signed && port_a[WIDTH-1]) ? -port_a : port_a;
  assign b_mag     = (op_signed && port_b[WIDTH-1]) ? -port_b : port_b;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: state_d = accept_md ? CALC : IDLE;
      CALC:       if (flush) state_d = IDLE;
                  else if (cnt_q == 5'd0) state_d = FIX;
      FIX:        state_d = flush ? IDLE : DONE;
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == CALC) || (state_q == FIX);
    done = (state_q == DONE);
  end

  // acc holds {partial product | remainder, multiplier | dividend->quotient}.
  logic [WIDTH:0]     mul_sum, div_sh;
  logic               div_ge;
  logic [WIDTH-1:0]   div_rem;
  logic [2*WIDTH-1:0] acc_step, prod;
  logic [WIDTH-1:0]   quot, rem, fix_hi, fix_lo;

  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
    div_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_ge   = div_sh >= {1'b0, b_q};
    div_rem  = div_ge ? WIDTH'(div_sh - {1'b0, b_q}) : div_sh[WIDTH-1:0];
    acc_step = is_div_q ? {div_rem, acc_q[WIDTH-2:0], div_ge}
                        : {mul_sum, acc_q[WIDTH-1:1]};

    prod = neg_q ? -acc_q : acc_q;
    quot = acc_q[WIDTH-1:0];
    rem  = acc_q[2*WIDTH-1:WIDTH];
    if (!is_div_q) begin
      fix_hi = prod[2*WIDTH-1:WIDTH];
      fix_lo = prod[WIDTH-1:0];
    end else if (divz_q) begin
      fix_hi = a_raw_q;
      fix_lo = '1;
    end else begin
      fix_hi = rem_neg_q ? -rem : rem;
      fix_lo = neg_q ? -quot : quot;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt_q     <= '0;
      acc_q     <= '0;
      b_q       <= '0;
      a_raw_q   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      divz_q    <= 1'b0;
    end else begin
      if (accept_md) begin
        cnt_q     <= 5'(WIDTH-1);
        acc_q     <= {{WIDTH{1'b0}}, a_mag};
        b_q       <= b_mag;
        a_raw_q   <= port_a;
        is_div_q  <= op_div;
        neg_q     <= op_signed && (port_a[WIDTH-1] ^ port_b[WIDTH-1]);
        rem_neg_q <= op_signed && port_a[WIDTH-1];
        divz_q    <= op_div && (port_b == '0);
      end
      if (accept_mt) begin
        if (op == MD_MTHI) hi_q <= port_a;
        else               lo_q <= port_a;
      end
      if (state_q == CALC && !flush) begin
        acc_q <= acc_step;
        cnt_q <= cnt_q - 5'd1;
      end
      if (state_q == FIX && !flush) begin
        hi_q <= fix_hi;
        lo_q <= fix_lo;
      end
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

- Multi-cycle integer multiply/divide unit in the execute stage, beside the ALU.
- Takes the same operand words the ALU receives.
- Runs MIPS MULT/MULTU/DIV/DIVU iteratively over 34 cycles and holds results in architectural HI/LO registers, which the EX result mux reads for MFHI/MFLO.
- Also takes MTHI/MTLO writes.
- Hazard unit stalls the pipeline while `busy` is high.

## Interface
Parameters:
- `WIDTH`, 32, operand/result width; equals word_t width.

Ports:
- `CLK`  in  1  clock; all state updates on rising edge.
- `nRST`  in  1  reset, asynchronous, active-low.
- `start`  in  1  request valid; sampled only when `busy`=0.
- `op`  in  muldiv_op_t  operation select.
- `port_a`  in  word_t  rs operand (multiplicand / dividend / MT source).
- `port_b`  in  word_t  rt operand (multiplier / divisor).
- `flush`  in  1  abort in-flight operation (branch/exception squash).
- `busy`  out  1  operation in flight; hazard unit stalls EX while high.
- `done`  out  1  one-cycle pulse: HI/LO just updated by mult/div.
- `hi`  out  word_t  HI register.
- `lo`  out  word_t  LO register.

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - `start`=1, `flush`=0, op in {MULT, MULTU, DIV, DIVU}: latch operand magnitudes (signed ops take absolute value; record result signs), counter=31, go CALC.
  - `start`=1, op MTHI: `hi`<=`port_a`; MTLO: `lo`<=`port_a`. Stay IDLE, no `busy`, no `done`.
- CALC: one radix-2 step per cycle.
  - Multiply: shift-add into a 64-bit accumulator.
  - Divide: restoring shift-subtract, 32-bit remainder, 32-bit quotient.
  - Counter decrements; at 0 go FIX.
- FIX:
  - Apply sign correction.
  - Signed MULT: negate 64-bit product if signs differ.
  - Signed DIV: negate quotient if signs differ; remainder takes dividend sign.
  - Write `hi`/`lo` at end of cycle; go DONE.
- Results:
  - MULT*: `hi`=product[63:32], `lo`=product[31:0].
  - DIV*: `lo`=quotient, `hi`=remainder.
- DONE: `done`=1 for one cycle, `busy`=0. Go IDLE, or accept a new `start` in the same cycle (DONE behaves as IDLE for acceptance).
- Divide by zero:
  - Runs full latency.
  - `lo`=0xFFFFFFFF; `hi`=`port_a` as issued.
  - Applies to signed and unsigned alike.
- DIV 0x80000000 / 0xFFFFFFFF: `lo`=0x80000000, `hi`=0 (no trap).
- `start` while `busy`=1: ignored; no queueing.
- `flush` in CALC or FIX: go IDLE at next edge; `hi`/`lo` unchanged, no `done`.
- `flush` with `start` in IDLE: flush wins; nothing accepted, including MTHI/MTLO.
- `nRST` low at any time: immediately IDLE.
  - `hi`=0, `lo`=0, `busy`=0, `done`=0.
  - Internal accumulator and counter cleared.

## Timing
- Cycle 0: `start` high, unit idle; accepted at end of cycle 0.
- Cycles 1–32: CALC, `busy`=1.
- Cycle 33: FIX, `busy`=1; `hi`/`lo` written at end.
- Cycle 34: `done`=1, `busy`=0, new `hi`/`lo` visible.
- Back-to-back ops: `start` in cycle 34 accepted; next result in cycle 68.
- MTHI/MTLO: new value visible in cycle 1; `busy` never asserts.
- `hi`/`lo` are driven straight from registers.
- No combinational path from any input to `busy`, `done`, `hi` or `lo`.

## Structure
- cpu_types_pkg gains:
  - muldiv_op_t enum: MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO.
  - muldiv_state_t enum: IDLE, CALC, FIX, DONE.
- New interface `muldiv_if` in include/, with modports `md` (unit) and `tb` (bench), built like the ALU interface.
- Single module, no sub-modules.
- The 5-bit step counter stays internal.

## Test plan
- Reset mid-CALC (nRST low at cycle 10) -> `busy`=0, `done`=0, `hi`=`lo`=0 immediately; next `start` behaves normally.
- MULT 0xFFFFFFFE × 0x00000003 -> cycle 34: `done`=1, `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFA. Same operands as MULTU -> `hi`=0x00000002, `lo`=0xFFFFFFFA.
- DIV 0xFFFFFFF9 (−7) / 2 -> `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. DIVU 7/0 -> `lo`=0xFFFFFFFF, `hi`=7.
- DIV 0x80000000 / 0xFFFFFFFF -> `lo`=0x80000000, `hi`=0.
- MULTU in flight:
  - `start` held during busy -> ignored.
  - `flush` at cycle 20 -> IDLE next cycle; `hi`/`lo` keep prior values; no `done`.
- MTHI 0x12345678 then MTLO 0x9ABCDEF0 in consecutive idle cycles -> visible in cycles 1 and 2, `busy` stays 0. Then back-to-back MULTU 2×3, 4×5 -> `lo`=6 at cycle 34, `lo`=20 at cycle 68.
